// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths, result-reader FSM states, int8 saturation bounds.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package npu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    RR_IDLE   = 2'd0,
    RR_STREAM = 2'd1,
    RR_DONE   = 2'd2
  } rr_state_t;

  // Two's-complement range of a w-bit signed value (w up to 31).
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int SAT_MAX_DEF = sat_max(DATA_WIDTH_DEF);
  localparam int SAT_MIN_DEF = sat_min(DATA_WIDTH_DEF);

endpackage

// File: rtl/requant_sat.sv
// Requantizer: arithmetic shift, optional ReLU, saturate an accumulator to a narrow signed element.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module requant_sat
  import npu_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SHIFT      = 0,
  parameter int RELU       = 1
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  output logic signed [DATA_WIDTH-1:0] data_out
);

  localparam logic signed [ACC_WIDTH-1:0]  HI_A = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0]  LO_A = ACC_WIDTH'(sat_min(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] HI_D = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] LO_D = DATA_WIDTH'(sat_min(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0] shifted;

  // Shift (floor division by 2^SHIFT), clamp negatives when ReLU is on, then saturate.
  always_comb begin
    shifted = acc_in >>> SHIFT;
    if ((RELU != 0) && (shifted < 0)) begin
      shifted = '0;
    end
    if (shifted > HI_A) begin
      data_out = HI_D;
    end else if (shifted < LO_A) begin
      data_out = LO_D;
    end else begin
      data_out = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fc_result_reader.sv
// Captures the fc accumulator vector on finish, streams requantized elements, reports argmax class.
// Latency: first beat valid the cycle after finish; class_valid NUM_OUTPUTS+1 cycles after finish at best.
// Backpressure: m_ready low stalls the stream with data/index/last held; no comb path from m_ready.
module fc_result_reader
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int NUM_OUTPUTS = 10,
  parameter int SHIFT       = 0,
  parameter int RELU        = 1,
  parameter int IDX_W       = $clog2(NUM_OUTPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             finish,
  input  logic [NUM_OUTPUTS*ACC_WIDTH-1:0] out_vec_flat,
  output logic                             busy,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [IDX_W-1:0]                 m_index,
  output logic                             m_last,
  output logic                             class_valid,
  output logic [IDX_W-1:0]                 class_idx,
  output logic [ACC_WIDTH-1:0]             class_score,
  output logic                             overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

  rr_state_t                   state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0] cap_q [NUM_OUTPUTS];
  logic signed [ACC_WIDTH-1:0] cap_d [NUM_OUTPUTS];
  // Running argmax over the beats transferred so far.
  logic signed [ACC_WIDTH-1:0] max_score_q, max_score_d;
  logic [IDX_W-1:0]            max_idx_q, max_idx_d;
  // Published result, only rewritten when a full stream completes.
  logic signed [ACC_WIDTH-1:0] class_score_q, class_score_d;
  logic [IDX_W-1:0]            class_idx_q, class_idx_d;
  logic                        overrun_q, overrun_d;

  logic signed [ACC_WIDTH-1:0] cur_acc;
  logic                        xfer;

  assign cur_acc = cap_q[idx_q];

  // m_data is a pure function of the captured register and index, so it holds during stalls.
  requant_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT      (SHIFT),
    .RELU       (RELU)
  ) u_requant (
    .acc_in   (cur_acc),
    .data_out (m_data)
  );

  assign busy        = (state_q != RR_IDLE);
  assign m_valid     = (state_q == RR_STREAM);
  assign m_index     = idx_q;
  assign m_last      = m_valid && (idx_q == LAST_IDX);
  assign class_valid = (state_q == RR_DONE);
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;
  assign overrun     = overrun_q;
  assign xfer        = m_valid && m_ready;

  // Next-state: capture on finish when idle, advance on each transfer, publish argmax on the last beat.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cap_d         = cap_q;
    max_score_d   = max_score_q;
    max_idx_d     = max_idx_q;
    class_score_d = class_score_q;
    class_idx_d   = class_idx_q;
    overrun_d     = overrun_q;

    // A finish while a result is still draining is dropped but remembered.
    if (finish && (state_q != RR_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      RR_IDLE: begin
        if (finish) begin
          for (int k = 0; k < NUM_OUTPUTS; k++) begin
            cap_d[k] = out_vec_flat[(k+1)*ACC_WIDTH-1 -: ACC_WIDTH];
          end
          idx_d   = '0;
          state_d = RR_STREAM;
        end
      end
      RR_STREAM: begin
        if (xfer) begin
          // Element 0 seeds the max; strict compare keeps the lowest index on ties.
          if ((idx_q == '0) || (cur_acc > max_score_q)) begin
            max_score_d = cur_acc;
            max_idx_d   = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            class_score_d = max_score_d;
            class_idx_d   = max_idx_d;
            state_d       = RR_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RR_DONE: begin
        idx_d   = '0;
        state_d = RR_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = RR_IDLE;
      end
    endcase
  end

  // State, capture and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RR_IDLE;
      idx_q         <= '0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        cap_q[k] <= '0;
      end
      max_score_q   <= '0;
      max_idx_q     <= '0;
      class_score_q <= '0;
      class_idx_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cap_q         <= cap_d;
      max_score_q   <= max_score_d;
      max_idx_q     <= max_idx_d;
      class_score_q <= class_score_d;
      class_idx_q   <= class_idx_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fc_result_reader.sv
// Bench for fc_result_reader: table of directed result vectors plus overrun, reset and shift/no-ReLU sequences.
// Latency: checks first beat at finish+1 and class_valid at finish+NUM_OUTPUTS+1+stalls.
// Backpressure: drives m_ready tied high or randomly toggled and checks stall stability.
module tb_fc_result_reader;

  localparam int N  = 10;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            finish;
  logic [N*AW-1:0] vec;
  logic            busy, m_valid, m_ready, m_last, class_valid, overrun;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   m_index, class_idx;
  logic [AW-1:0]   class_score;

  logic            finish_b;
  logic [N*AW-1:0] vec_b;
  logic            busy_b, m_valid_b, m_ready_b, m_last_b, class_valid_b, overrun_b;
  logic [DW-1:0]   m_data_b;
  logic [IW-1:0]   m_index_b, class_idx_b;
  logic [AW-1:0]   class_score_b;

  fc_result_reader #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_OUTPUTS(N), .SHIFT(0), .RELU(1)) u_dut (
    .clk(clk), .rst(rst), .finish(finish), .out_vec_flat(vec), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .class_valid(class_valid), .class_idx(class_idx), .class_score(class_score), .overrun(overrun)
  );

  fc_result_reader #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_OUTPUTS(N), .SHIFT(2), .RELU(0)) u_dut_b (
    .clk(clk), .rst(rst), .finish(finish_b), .out_vec_flat(vec_b), .busy(busy_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_index(m_index_b), .m_last(m_last_b),
    .class_valid(class_valid_b), .class_idx(class_idx_b), .class_score(class_score_b), .overrun(overrun_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0][AW-1:0] acc;
    logic [N-1:0][DW-1:0] data;
    int                   cidx;
    logic [AW-1:0]        score;
    bit                   bp;
  } row_t;

  function automatic row_t mk(input int a[N], input int d[N], input int ci, input int sc, input bit bp);
    row_t r;
    for (int k = 0; k < N; k++) begin
      r.acc[k]  = AW'(a[k]);
      r.data[k] = DW'(d[k]);
    end
    r.cidx  = ci;
    r.score = AW'(sc);
    r.bp    = bp;
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " m_valid"},     32'(m_valid),     32'd0);
    check({tag, " m_data"},      32'(m_data),      32'd0);
    check({tag, " m_index"},     32'(m_index),     32'd0);
    check({tag, " m_last"},      32'(m_last),      32'd0);
    check({tag, " class_valid"}, 32'(class_valid), 32'd0);
    check({tag, " class_idx"},   32'(class_idx),   32'd0);
    check({tag, " class_score"}, class_score,      32'd0);
    check({tag, " overrun"},     32'(overrun),     32'd0);
  endtask

  // Issue one finish with row r, drain the stream, check every beat and the class result.
  // ovr_at >= 0 fires a second finish (with junk data) while that index is on the bus.
  task automatic run_row(input row_t r, input string tag, input int ovr_at);
    int beats, stalls, cyc;
    bit done, pstall, ovr_fired, ovr_drop, rdy;
    logic [DW-1:0] pd;
    logic [IW-1:0] pi;
    logic          pl;
    beats = 0; stalls = 0; cyc = 0; done = 0; pstall = 0; ovr_fired = 0; ovr_drop = 0;
    pd = '0; pi = '0; pl = 1'b0;
    @(negedge clk);
    finish  = 1'b1;
    vec     = r.acc;
    m_ready = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        finish = 1'b0;
        vec    = ~r.acc;
        check($sformatf("%s busy@1", tag), 32'(busy), 32'd1);
        check($sformatf("%s m_valid@1", tag), 32'(m_valid), 32'd1);
      end
      if (ovr_drop) begin
        finish   = 1'b0;
        vec      = ~r.acc;
        ovr_drop = 0;
      end
      if (m_valid) begin
        if (pstall) begin
          check($sformatf("%s stall data", tag), 32'(m_data), 32'(pd));
          check($sformatf("%s stall index", tag), 32'(m_index), 32'(pi));
          check($sformatf("%s stall last", tag), 32'(m_last), 32'(pl));
        end
        rdy = r.bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_ready = rdy;
        if (rdy) begin
          check($sformatf("%s beat%0d index", tag, beats), 32'(m_index), 32'(beats));
          if (beats < N) begin
            check($sformatf("%s beat%0d data", tag, beats), 32'(m_data), 32'(r.data[beats]));
          end
          check($sformatf("%s beat%0d last", tag, beats), 32'(m_last), 32'(beats == N - 1));
          beats++;
        end else begin
          stalls++;
        end
        pstall = !rdy;
        pd = m_data; pi = m_index; pl = m_last;
        if (ovr_at >= 0 && !ovr_fired && m_index == IW'(ovr_at)) begin
          finish    = 1'b1;
          vec       = {N{32'hDEAD_BEEF}};
          ovr_fired = 1;
          ovr_drop  = 1;
        end
      end else begin
        pstall = 0;
      end
      if (class_valid) begin
        check($sformatf("%s class_valid cycle", tag), 32'(cyc), 32'(N + 1 + stalls));
        check($sformatf("%s beats before class", tag), 32'(beats), 32'(N));
        check($sformatf("%s class_idx", tag), 32'(class_idx), 32'(r.cidx));
        check($sformatf("%s class_score", tag), class_score, r.score);
        done = 1;
      end
    end
    if (!done) begin
      fails++;
      tests++;
      $display("FAIL %s timeout: got no class_valid after %0d cycles, expected one", tag, cyc);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check($sformatf("%s class_valid one-shot", tag), 32'(class_valid), 32'd0);
    check($sformatf("%s busy after class", tag), 32'(busy), 32'd0);
    check($sformatf("%s class_idx held", tag), 32'(class_idx), 32'(r.cidx));
    check($sformatf("%s class_score held", tag), class_score, r.score);
    if (ovr_at >= 0) begin
      check($sformatf("%s overrun set", tag), 32'(overrun), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[4];
    int   a[N];
    int   d[N];
    int   cv_cnt, wait_cyc;
    logic [N-1:0][AW-1:0] vb;
    logic [N-1:0][DW-1:0] db;

    a = '{49, 49, 49, 49, 49, 49, 49, 49, 49, 49};
    d = '{49, 49, 49, 49, 49, 49, 49, 49, 49, 49};
    rows[0] = mk(a, d, 0, 49, 1'b0);
    a = '{-300, 5, 1000, 1000, -1, 0, 200, 127, 128, 40};
    d = '{0, 5, 127, 127, 0, 0, 127, 127, 127, 40};
    rows[1] = mk(a, d, 2, 1000, 1'b0);
    a = '{100, -50, 300, 300, 7, -5, 90, 2, 1, 64};
    d = '{100, 0, 127, 127, 7, 0, 90, 2, 1, 64};
    rows[2] = mk(a, d, 2, 300, 1'b1);
    a = '{-5, -3, -9, -3, -100, -7, -8, -4, -6, -10};
    d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rows[3] = mk(a, d, 1, -3, 1'b1);

    rst = 1'b1; finish = 1'b0; vec = '0; m_ready = 1'b1;
    finish_b = 1'b0; vec_b = '0; m_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_row(rows[i], $sformatf("row%0d", i), -1);
    end
    check("no overrun yet", 32'(overrun), 32'd0);

    // Second finish mid-stream: flagged, ignored, stream intact; later finish accepted.
    run_row(rows[1], "overrun", 4);
    run_row(rows[0], "after overrun", -1);
    check("overrun sticky", 32'(overrun), 32'd1);

    // Reset while index 6 is on the bus.
    @(negedge clk);
    finish = 1'b1; vec = rows[2].acc; m_ready = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    wait_cyc = 0;
    while (!(m_valid && m_index == 4'd6) && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reached index 6", 32'(m_index), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid reset");
    cv_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (class_valid) cv_cnt++;
    end
    check("class_valid after abort", 32'(cv_cnt), 32'd0);
    run_row(rows[1], "post reset", -1);

    // Second instance: SHIFT=2, no ReLU.
    vb = '0;
    vb[0] = -32'sd1000;
    vb[1] = -32'sd9;
    vb[2] = 32'sd511;
    db = '0;
    db[0] = 8'h80;
    db[1] = 8'hFD;
    db[2] = 8'h7F;
    @(negedge clk);
    finish_b = 1'b1; vec_b = vb;
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge clk);
      finish_b = 1'b0;
      if (c <= N) begin
        check($sformatf("shift2 beat%0d data", c - 1), 32'(m_data_b), 32'(db[c-1]));
      end else begin
        check("shift2 class_valid", 32'(class_valid_b), 32'd1);
        check("shift2 class_idx", 32'(class_idx_b), 32'd2);
        check("shift2 class_score", class_score_b, 32'd511);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
